// File: rtl/test_status_pkg.sv
// Shared types and helpers for the multi-channel test status collector.
// Holds the FSM state encoding, the "no error yet" marker and a saturating adder.
// No logic of its own; imported by every collector file.
package test_status_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Wide enough for N_CH up to 16; callers truncate to their own width,
  // which keeps the value all-ones at any width.
  localparam logic [4:0] FIRST_ERR_NONE = 5'h1F;

  // Unsigned add that clamps at max instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max}) begin
      return max;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/test_status_collector_if.sv
// Bundle of control, compare-stream and result signals of the collector.
// master = stimulus side (bench or BIST engine), slave = collector.
// Per-channel check/error counts are exported for debug visibility.
interface test_status_collector_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  localparam int FE_W = $clog2(N_CH) + 1;

  logic                     start;
  logic                     stop;
  logic [N_CH-1:0]          chk_valid;
  logic [N_CH*DATA_W-1:0]   chk_expected;
  logic [N_CH*DATA_W-1:0]   chk_actual;

  logic                     busy;
  logic                     done;
  logic                     passed;
  logic                     failed;
  logic [CNT_W-1:0]         chk_total;
  logic [CNT_W-1:0]         err_total;
  logic [FE_W-1:0]          first_err_ch;
  logic                     timeout;
  logic [N_CH*CNT_W-1:0]    chan_chk_cnt;
  logic [N_CH*CNT_W-1:0]    chan_err_cnt;

  modport master (
    output start, stop, chk_valid, chk_expected, chk_actual,
    input  busy, done, passed, failed, chk_total, err_total,
           first_err_ch, timeout, chan_chk_cnt, chan_err_cnt
  );

  modport slave (
    input  start, stop, chk_valid, chk_expected, chk_actual,
    output busy, done, passed, failed, chk_total, err_total,
           first_err_ch, timeout, chan_chk_cnt, chan_err_cnt
  );

endinterface

// File: rtl/test_status_chan.sv
// One compare channel: checks an expected/actual word pair, keeps saturating counts.
// Latency: hit/mis pulses are combinational; counts update on the next edge.
// No backpressure: a strobe is consumed in the cycle it is presented while enabled.
module test_status_chan #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              vld,
  input  logic [DATA_W-1:0] exp_dat,
  input  logic [DATA_W-1:0] act_dat,
  output logic              hit,
  output logic              mis,
  output logic [CNT_W-1:0]  chk_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Compare this cycle's word pair and advance the saturating counts.
  always_comb begin
    hit       = en & vld;
    mis       = hit & (exp_dat != act_dat);
    chk_cnt_d = chk_cnt_q;
    err_cnt_d = err_cnt_q;
    if (clr) begin
      chk_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      if (hit && (chk_cnt_q != CNT_MAX)) chk_cnt_d = chk_cnt_q + 1'b1;
      if (mis && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      chk_cnt_q <= chk_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign chk_cnt = chk_cnt_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: rtl/test_status_collector.sv
// Multi-channel pass/fail collector with IDLE/RUN/DONE sequencing and registered verdict.
// Latency: totals visible 1 cycle after the strobe; done/passed/failed 1 cycle after stop.
// No backpressure; optional idle watchdog enabled by TEST_STATUS_TIMEOUT_EN.
module test_status_collector
  import test_status_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int DATA_W         = 8,
  parameter int CNT_W          = 16,
  parameter int MIN_CHECKS     = 1,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic                   clk,
  input logic                   rst,
  test_status_collector_if.slave bus
);

  localparam int FE_W = $clog2(N_CH) + 1;
  localparam int PC_W = $clog2(N_CH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [FE_W-1:0]  FE_NONE = FE_W'(FIRST_ERR_NONE);

  if ((N_CH < 1) || (N_CH > 16) || (CNT_W < 1) || (CNT_W > 31) || (TIMEOUT_CYCLES < 1)) begin : g_cfg_err
    $error("test_status_collector: illegal parameter set");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] chk_total_q, chk_total_d;
  logic [CNT_W-1:0] err_total_q, err_total_d;
  logic [FE_W-1:0]  first_err_q, first_err_d;
  logic             passed_q, passed_d;
  logic             failed_q, failed_d;
  logic             timeout_q, timeout_d;
  logic             clr;
  logic             run_en;
  logic             verdict_ok;
  logic             expire;

  logic [N_CH-1:0]       hit;
  logic [N_CH-1:0]       mis;
  logic [PC_W-1:0]       hit_cnt;
  logic [PC_W-1:0]       mis_cnt;
  logic [FE_W-1:0]       first_mis;
  logic [N_CH*CNT_W-1:0] chan_chk_cnt;
  logic [N_CH*CNT_W-1:0] chan_err_cnt;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    test_status_chan #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .en      (run_en),
      .vld     (bus.chk_valid[i]),
      .exp_dat (bus.chk_expected[i*DATA_W +: DATA_W]),
      .act_dat (bus.chk_actual[i*DATA_W +: DATA_W]),
      .hit     (hit[i]),
      .mis     (mis[i]),
      .chk_cnt (chan_chk_cnt[i*CNT_W +: CNT_W]),
      .err_cnt (chan_err_cnt[i*CNT_W +: CNT_W])
    );
  end

  // Per-cycle popcounts of accepted checks and mismatches, plus lowest mismatching channel.
  always_comb begin
    hit_cnt   = '0;
    mis_cnt   = '0;
    first_mis = FE_NONE;
    for (int i = 0; i < N_CH; i++) begin
      hit_cnt = hit_cnt + PC_W'(hit[i]);
      mis_cnt = mis_cnt + PC_W'(mis[i]);
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mis[i]) first_mis = FE_W'(i);
    end
  end

`ifdef TEST_STATUS_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);

  logic [IDLE_W-1:0] idle_q, idle_d;

  // Count consecutive silent RUN cycles; expiry is acted on one cycle after the limit is reached.
  always_comb begin
    idle_d = idle_q;
    expire = (state_q == ST_RUN) && (idle_q == IDLE_LIMIT);
    if (clr) begin
      idle_d = '0;
    end else if (state_q == ST_RUN) begin
      if (|bus.chk_valid)          idle_d = '0;
      else if (idle_q != IDLE_LIMIT) idle_d = idle_q + 1'b1;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  assign expire = 1'b0;
`endif

  // Sequencing, counter accumulation and next-cycle verdict.
  always_comb begin
    state_d     = state_q;
    clr         = 1'b0;
    run_en      = (state_q == ST_RUN);
    chk_total_d = chk_total_q;
    err_total_d = err_total_q;
    first_err_d = first_err_q;
    timeout_d   = timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          clr     = 1'b1;
        end
      end
      ST_RUN: begin
        // stop outranks both start and a coincident watchdog expiry
        if (bus.stop) begin
          state_d = ST_DONE;
        end else if (expire) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          clr     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (clr) begin
      chk_total_d = '0;
      err_total_d = '0;
      first_err_d = FE_NONE;
      timeout_d   = 1'b0;
    end else if (run_en) begin
      chk_total_d = CNT_W'(sat_add(32'(chk_total_q), 32'(hit_cnt), 32'(CNT_MAX)));
      err_total_d = CNT_W'(sat_add(32'(err_total_q), 32'(mis_cnt), 32'(CNT_MAX)));
      if ((first_err_q == FE_NONE) && (|mis)) first_err_d = first_mis;
    end

    verdict_ok = (err_total_d == '0) && (int'(chk_total_d) >= MIN_CHECKS) && !timeout_d;
    passed_d   = (state_d == ST_DONE) && verdict_ok;
    failed_d   = (state_d == ST_DONE) && !verdict_ok;
  end

  // State, totals and verdict registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      chk_total_q <= '0;
      err_total_q <= '0;
      first_err_q <= FE_NONE;
      passed_q    <= 1'b0;
      failed_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      chk_total_q <= chk_total_d;
      err_total_q <= err_total_d;
      first_err_q <= first_err_d;
      passed_q    <= passed_d;
      failed_q    <= failed_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.busy         = (state_q == ST_RUN);
  assign bus.done         = (state_q == ST_DONE);
  assign bus.passed       = passed_q;
  assign bus.failed       = failed_q;
  assign bus.chk_total    = chk_total_q;
  assign bus.err_total    = err_total_q;
  assign bus.first_err_ch = first_err_q;
  assign bus.timeout      = timeout_q;
  assign bus.chan_chk_cnt = chan_chk_cnt;
  assign bus.chan_err_cnt = chan_err_cnt;

endmodule

// File: tb/tb_test_status_collector.sv
// Bench for test_status_collector: directed plus random tests against a test-level model.
// Two DUTs share stimulus: 16-bit counters and 4-bit counters (saturation coverage).
// Expected verdicts go into queues; a negedge monitor pops them when done rises.
module tb_test_status_collector;

  localparam int N_CH    = 4;
  localparam int DATA_W  = 8;
  localparam int CNT_BIG = 16;
  localparam int CNT_SML = 4;
  localparam int MIN_CHK = 1;
  localparam int TMO     = 20;
  localparam int FE_W    = $clog2(N_CH) + 1;
  localparam int NONE    = (1 << FE_W) - 1;
  localparam int MAX_BIG = (1 << CNT_BIG) - 1;
  localparam int MAX_SML = (1 << CNT_SML) - 1;
  localparam logic [N_CH-1:0] ALL = '1;

  typedef struct {
    int chk;
    int err;
    int first;
    bit to;
    int ch_chk[N_CH];
    int ch_err[N_CH];
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  test_status_collector_if #(.N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_BIG)) tif ();
  test_status_collector_if #(.N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_SML)) sif ();

  test_status_collector #(.N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_BIG),
                          .MIN_CHECKS(MIN_CHK), .TIMEOUT_CYCLES(TMO))
    dut (.clk(clk), .rst(rst), .bus(tif));

  test_status_collector #(.N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_SML),
                          .MIN_CHECKS(MIN_CHK), .TIMEOUT_CYCLES(TMO))
    dut_s (.clk(clk), .rst(rst), .bus(sif));

  assign sif.start        = tif.start;
  assign sif.stop         = tif.stop;
  assign sif.chk_valid    = tif.chk_valid;
  assign sif.chk_expected = tif.chk_expected;
  assign sif.chk_actual   = tif.chk_actual;

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q_big[$];
  exp_t q_sml[$];
  exp_t e_last;

  // test-level model state
  bit m_live = 0;
  int m_chk, m_err, m_first, m_idle;
  int m_ch_chk[N_CH];
  int m_ch_err[N_CH];

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [N_CH*DATA_W-1:0] flip(input logic [N_CH*DATA_W-1:0] ex,
                                                  input logic [N_CH-1:0] m);
    logic [N_CH*DATA_W-1:0] r;
    r = ex;
    for (int i = 0; i < N_CH; i++)
      if (m[i]) r[i*DATA_W +: DATA_W] = ~ex[i*DATA_W +: DATA_W];
    return r;
  endfunction

  function automatic logic [N_CH*DATA_W-1:0] rnd_words();
    logic [N_CH*DATA_W-1:0] r;
    for (int i = 0; i < N_CH; i++) r[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_end(input bit to);
    exp_t e;
    e.chk = m_chk; e.err = m_err; e.first = m_first; e.to = to;
    for (int i = 0; i < N_CH; i++) begin
      e.ch_chk[i] = m_ch_chk[i];
      e.ch_err[i] = m_ch_err[i];
    end
    q_big.push_back(e);
    q_sml.push_back(e);
    e_last = e;
    m_live = 0;
  endtask

  // start cycle: data strobes here must be ignored
  task automatic test_begin();
    tif.start        = 1'b1;
    tif.stop         = 1'($urandom_range(0, 1));
    tif.chk_valid    = N_CH'($urandom);
    tif.chk_expected = rnd_words();
    tif.chk_actual   = rnd_words();
    tick();
    m_live = 1; m_chk = 0; m_err = 0; m_first = NONE; m_idle = 0;
    for (int i = 0; i < N_CH; i++) begin
      m_ch_chk[i] = 0;
      m_ch_err[i] = 0;
    end
  endtask

  // one RUN cycle; the model decides whether the test ends here
  task automatic step(input logic [N_CH-1:0] v, input logic [N_CH*DATA_W-1:0] ex,
                      input logic [N_CH*DATA_W-1:0] ac, input bit stp, input bit st);
    tif.start = st; tif.stop = stp; tif.chk_valid = v;
    tif.chk_expected = ex; tif.chk_actual = ac;
    for (int i = 0; i < N_CH; i++) begin
      if (v[i]) begin
        m_chk++; m_ch_chk[i]++;
        if (ex[i*DATA_W +: DATA_W] != ac[i*DATA_W +: DATA_W]) begin
          m_err++; m_ch_err[i]++;
          if (m_first == NONE) m_first = i;
        end
      end
    end
    if (stp) model_end(0);
`ifdef TEST_STATUS_TIMEOUT_EN
    else if (m_idle == TMO) model_end(1);
`endif
    else if (v == '0) m_idle++;
    else m_idle = 0;
    tick();
  endtask

  task automatic rand_step(input int mis_pct, input bit stp);
    logic [N_CH-1:0] v, mm;
    logic [N_CH*DATA_W-1:0] ex;
    v = N_CH'($urandom);
    if ($urandom_range(0, 3) == 0) v = '0;
    for (int i = 0; i < N_CH; i++) mm[i] = ($urandom_range(0, 99) < mis_pct);
    ex = rnd_words();
    step(v, ex, flip(ex, mm), stp, ($urandom_range(0, 3) == 0));
  endtask

  task automatic wait_done(output int waited);
    waited = 0;
    tif.start = 0; tif.stop = 0; tif.chk_valid = '0;
    while (!tif.done && waited < 50) begin
      tick();
      waited++;
    end
    if (!tif.done) check("done_wait_expired", 0, 1);
  endtask

  // DONE holds its results whatever the inputs do, as long as start is low
  task automatic hold_check();
    for (int k = 0; k < 2; k++) begin
      tif.start = 0; tif.stop = 1'($urandom_range(0, 1));
      tif.chk_valid = N_CH'($urandom);
      tif.chk_expected = rnd_words(); tif.chk_actual = rnd_words();
      tick();
    end
    check("hold_done", tif.done, 1);
    check("hold_chk_total", tif.chk_total, sat(e_last.chk, MAX_BIG));
    check("hold_err_total", tif.err_total, sat(e_last.err, MAX_BIG));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, tif.busy, 0);
    check({tag, "_done"}, tif.done, 0);
    check({tag, "_passed"}, tif.passed, 0);
    check({tag, "_failed"}, tif.failed, 0);
    check({tag, "_timeout"}, tif.timeout, 0);
    check({tag, "_chk_total"}, tif.chk_total, 0);
    check({tag, "_err_total"}, tif.err_total, 0);
    check({tag, "_first_err"}, tif.first_err_ch, NONE);
    check({tag, "_s_chk_total"}, sif.chk_total, 0);
    check({tag, "_s_first_err"}, sif.first_err_ch, NONE);
  endtask

  task automatic check_done(input string tag, input exp_t e, input int mx,
                            input int chk, input int err, input int first,
                            input bit p, input bit f, input bit to, input bit bsy,
                            input int cc[N_CH], input int ce[N_CH]);
    bit pass_exp;
    pass_exp = (e.err == 0) && (e.chk >= MIN_CHK) && !e.to;
    check({tag, "_chk_total"}, chk, sat(e.chk, mx));
    check({tag, "_err_total"}, err, sat(e.err, mx));
    check({tag, "_first_err_ch"}, first, e.first);
    check({tag, "_passed"}, p, pass_exp);
    check({tag, "_failed"}, f, !pass_exp);
    check({tag, "_timeout"}, to, e.to);
    check({tag, "_busy"}, bsy, 0);
    for (int i = 0; i < N_CH; i++) begin
      check({tag, "_chan_chk"}, cc[i], sat(e.ch_chk[i], mx));
      check({tag, "_chan_err"}, ce[i], sat(e.ch_err[i], mx));
    end
  endtask

  // monitor: pops an expected verdict whenever done rises on either DUT
  bit   big_prev = 0;
  bit   sml_prev = 0;
  exp_t me;
  int   mcc[N_CH];
  int   mce[N_CH];
  always @(negedge clk) begin
    if (rst) begin
      big_prev = 0;
      sml_prev = 0;
    end else begin
      check("excl_passed_failed", tif.passed & tif.failed, 0);
      check("verdict_outside_done", (tif.passed | tif.failed) & ~tif.done, 0);
      if (tif.done && !big_prev) begin
        if (q_big.size() == 0) check("unexpected_done_big", 1, 0);
        else begin
          me = q_big.pop_front();
          for (int i = 0; i < N_CH; i++) begin
            mcc[i] = int'(tif.chan_chk_cnt[i*CNT_BIG +: CNT_BIG]);
            mce[i] = int'(tif.chan_err_cnt[i*CNT_BIG +: CNT_BIG]);
          end
          check_done("big", me, MAX_BIG, int'(tif.chk_total), int'(tif.err_total),
                     int'(tif.first_err_ch), tif.passed, tif.failed, tif.timeout,
                     tif.busy, mcc, mce);
        end
      end
      if (sif.done && !sml_prev) begin
        if (q_sml.size() == 0) check("unexpected_done_small", 1, 0);
        else begin
          me = q_sml.pop_front();
          for (int i = 0; i < N_CH; i++) begin
            mcc[i] = int'(sif.chan_chk_cnt[i*CNT_SML +: CNT_SML]);
            mce[i] = int'(sif.chan_err_cnt[i*CNT_SML +: CNT_SML]);
          end
          check_done("small", me, MAX_SML, int'(sif.chk_total), int'(sif.err_total),
                     int'(sif.first_err_ch), sif.passed, sif.failed, sif.timeout,
                     sif.busy, mcc, mce);
        end
      end
      big_prev = tif.done;
      sml_prev = sif.done;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_watchdog: got no finish, required finish before %0t", $time);
    $fatal(1, "simulation stalled");
  end

  initial begin
    logic [N_CH*DATA_W-1:0] ex;
    int w, silent, n;

    tif.start = 0; tif.stop = 0; tif.chk_valid = '0;
    tif.chk_expected = '0; tif.chk_actual = '0;
    rst = 1;
    repeat (3) tick();
    check_reset("reset");
    rst = 0;

    // IDLE ignores stop and strobes
    tif.stop = 1; tif.chk_valid = ALL;
    ex = rnd_words(); tif.chk_expected = ex; tif.chk_actual = flip(ex, ALL);
    repeat (3) tick();
    check_reset("idle_ignore");

    // clean pass: 10 cycles of all-valid matching data
    test_begin();
    for (int k = 0; k < 10; k++) begin
      ex = rnd_words();
      step(ALL, ex, ex, 0, 0);
    end
    step('0, rnd_words(), rnd_words(), 1, 0);
    wait_done(w);
    check("stop_to_done_latency", w, 0);
    check("clean_passed", tif.passed, 1);
    check("clean_chk_total", tif.chk_total, 40);
    hold_check();

    // multi-error: ch1+ch2 together, later ch0
    test_begin();
    ex = rnd_words(); step(ALL, ex, ex, 0, 0);
    ex = rnd_words(); step(ALL, ex, flip(ex, 4'b0110), 0, 0);
    ex = rnd_words(); step(ALL, ex, ex, 0, 0);
    ex = rnd_words(); step(ALL, ex, flip(ex, 4'b0001), 0, 0);
    step('0, rnd_words(), rnd_words(), 1, 1);
    wait_done(w);
    check("multi_first_err", tif.first_err_ch, 1);
    check("multi_err_total", tif.err_total, 3);
    hold_check();

    // no checks at all
    test_begin();
    step('0, rnd_words(), rnd_words(), 1, 0);
    wait_done(w);
    check("nochk_failed", tif.failed, 1);

    // saturation of the narrow-counter instance
    test_begin();
    for (int k = 0; k < 5; k++) begin
      ex = rnd_words();
      step(ALL, ex, flip(ex, ALL), 0, 0);
    end
    step('0, rnd_words(), rnd_words(), 1, 0);
    wait_done(w);
    check("sat_small_chk", sif.chk_total, 15);
    check("sat_small_err", sif.err_total, 15);
    hold_check();

`ifdef TEST_STATUS_TIMEOUT_EN
    // watchdog expiry after silence
    test_begin();
    for (int k = 0; k < 3; k++) begin
      ex = rnd_words();
      step(ALL, ex, ex, 0, 0);
    end
    silent = 0;
    while (m_live && silent < 40) begin
      step('0, rnd_words(), rnd_words(), 0, 0);
      silent++;
    end
    wait_done(w);
    check("timeout_latency", silent + w, 21);
    check("timeout_flag", tif.timeout, 1);

    // stop coinciding with expiry wins
    test_begin();
    for (int k = 0; k < 3; k++) begin
      ex = rnd_words();
      step(ALL, ex, ex, 0, 0);
    end
    for (int k = 0; k < TMO; k++) step('0, rnd_words(), rnd_words(), 0, 0);
    step('0, rnd_words(), rnd_words(), 1, 0);
    wait_done(w);
    check("stop_at_expiry_timeout", tif.timeout, 0);
    check("stop_at_expiry_passed", tif.passed, 1);
`endif

    // reset in the middle of RUN after 5 checks
    test_begin();
    ex = rnd_words(); step(ALL, ex, ex, 0, 0);
    ex = rnd_words(); step(4'b0001, ex, flip(ex, 4'b0001), 0, 0);
    #2;
    rst = 1;
    m_live = 0;
    #1;
    check_reset("mid_run_reset");
    tick();
    rst = 0;
    tick();
    check_reset("after_reset");

    // new test starts counting from zero
    test_begin();
    for (int k = 0; k < 3; k++) begin
      ex = rnd_words();
      step(ALL, ex, ex, 0, 0);
    end
    step('0, rnd_words(), rnd_words(), 1, 0);
    wait_done(w);
    check("restart_chk_total", tif.chk_total, 12);

    // random tests
    for (int t = 0; t < 30; t++) begin
      test_begin();
      n = $urandom_range(1, 25);
      for (int k = 0; k < n && m_live; k++) rand_step((t % 3 == 0) ? 0 : 8, (k == n - 1));
      wait_done(w);
      hold_check();
    end

    repeat (3) tick();
    check("queues_drained", q_big.size() + q_sml.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
